// File: rtl/micro_pkg.sv
// Shared micro-core constants: phase vector bit positions and clear-FSM encoding.
// Imported by the register file, its clear sequencer and the bus interface.
package micro_pkg;

  localparam int PH_WIDTH = 5;
  localparam int PH_W     = 0;
  localparam int PH_M     = 1;
  localparam int PH_X     = 2;
  localparam int PH_R     = 3;
  localparam int PH_F     = 4;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_CLR  = 1'b1;

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/write-back facing bus of the phase-gated register file.
// master = core side driving addresses/data, slave = register file.
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int N_RD   = 2
);
  import micro_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic [PH_WIDTH-1:0]     phase;
  logic [N_RD*AW-1:0]      ra;
  logic [N_RD*DATA_W-1:0]  rd;
  logic                    rd_vld;
  logic [AW-1:0]           wa;
  logic [DATA_W-1:0]       wd;
  logic                    we;
  logic                    wr_drop;
  logic                    clr_req;
  logic                    clr_busy;
  logic                    clr_done;
  logic [DEPTH*DATA_W-1:0] rf_flat;

  modport master (
    output phase, ra, wa, wd, we, clr_req,
    input  rd, rd_vld, wr_drop, clr_busy, clr_done, rf_flat
  );

  modport slave (
    input  phase, ra, wa, wd, we, clr_req,
    output rd, rd_vld, wr_drop, clr_busy, clr_done, rf_flat
  );

endinterface

// File: rtl/rf_clear_seq.sv
// Clear sequencer: walks the file one word per cycle from address 0 to DEPTH-1.
// clr_req is only honoured while idle; clr_done pulses the cycle after the last word.
module rf_clear_seq
  import micro_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_req,
  output logic          clr_busy,
  output logic          clr_done,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);

  logic [0:0] state;
  logic [AW:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      clr_done <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (clr_req) begin
            state <= ST_CLR;
            cnt   <= '0;
          end
        end
        ST_CLR: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state    <= ST_IDLE;
            clr_done <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign clr_busy = (state == ST_CLR);
  assign clr_we   = clr_busy;
  assign clr_addr = cnt[AW-1:0];

endmodule

// File: rtl/regfile_mp.sv
// Phase-gated multi-read-port register file with write-first bypass and a clear sequencer.
// Define ZERO_REG_EN to hardwire word 0 to zero.
module regfile_mp
  import micro_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int N_RD   = 2
) (
  input  logic        clk,
  input  logic        rst,
  regfile_mp_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem  [DEPTH];
  logic [DATA_W-1:0] rd_r [N_RD];

  logic          clr_busy;
  logic          clr_we;
  logic [AW-1:0] clr_addr;
  logic          wr_q;
  logic          wr_ok;
  logic          wr_acc;

  logic [N_RD*DATA_W-1:0]  rd_flat;
  logic [DEPTH*DATA_W-1:0] img_flat;
  logic                    unused_phase;

  rf_clear_seq #(.DEPTH(DEPTH), .AW(AW)) u_clr (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (bus.clr_req),
    .clr_busy (clr_busy),
    .clr_done (bus.clr_done),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign wr_q = bus.phase[PH_W] & bus.we;

  // Writes to word 0 vanish entirely when it is hardwired, so they never count as dropped.
`ifdef ZERO_REG_EN
  assign wr_ok = (bus.wa != '0);
`else
  assign wr_ok = 1'b1;
`endif

  assign wr_acc = wr_q & ~clr_busy & wr_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_acc) begin
      mem[bus.wa] <= bus.wd;
    end
  end

  // Read latch samples pre-edge storage; an accepted write to the same word wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_RD; k++) rd_r[k] <= '0;
      bus.rd_vld  <= 1'b0;
      bus.wr_drop <= 1'b0;
    end else begin
      bus.rd_vld  <= bus.phase[PH_R];
      bus.wr_drop <= wr_q & clr_busy & wr_ok;
      if (bus.phase[PH_R]) begin
        for (int k = 0; k < N_RD; k++) begin
          if (wr_acc && (bus.ra[k*AW +: AW] == bus.wa))
            rd_r[k] <= bus.wd;
          else
            rd_r[k] <= mem[bus.ra[k*AW +: AW]];
        end
      end
    end
  end

  always_comb begin
    rd_flat = '0;
    for (int k = 0; k < N_RD; k++) rd_flat[k*DATA_W +: DATA_W] = rd_r[k];
  end

  always_comb begin
    img_flat = '0;
    for (int i = 0; i < DEPTH; i++) img_flat[(DEPTH-1-i)*DATA_W +: DATA_W] = mem[i];
  end

  assign bus.rd       = rd_flat;
  assign bus.rf_flat  = img_flat;
  assign bus.clr_busy = clr_busy;

  assign unused_phase = &{bus.phase[PH_F], bus.phase[PH_X], bus.phase[PH_M]};

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed scenarios plus randomized traffic against a word-array model.
module tb_regfile_mp;
  import micro_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int NRD   = 2;
  localparam int AW    = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_mp_if #(.DATA_W(DW), .DEPTH(DEPTH), .N_RD(NRD)) bus_if ();

  regfile_mp #(.DATA_W(DW), .DEPTH(DEPTH), .N_RD(NRD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int n_vec  = 0;
  int n_miss = 0;

  logic [DW-1:0] m_mem [DEPTH];
  logic [DW-1:0] m_rd  [NRD];
  int            m_rem;
  bit            m_vld, m_drop, m_done;

  function automatic logic [DW-1:0] rfw(int i);
    return bus_if.rf_flat[(DEPTH-1-i)*DW +: DW];
  endfunction

  function automatic logic [DEPTH*DW-1:0] model_flat();
    logic [DEPTH*DW-1:0] f;
    for (int i = 0; i < DEPTH; i++) f[(DEPTH-1-i)*DW +: DW] = m_mem[i];
    return f;
  endfunction

  function automatic logic [NRD*DW-1:0] model_rd();
    logic [NRD*DW-1:0] f;
    for (int k = 0; k < NRD; k++) f[k*DW +: DW] = m_rd[k];
    return f;
  endfunction

  // Advance one clock: model computes from the rules using pre-edge inputs.
  task automatic tick();
    logic [DW-1:0] nm [DEPTH];
    logic [DW-1:0] nr [NRD];
    int nrem;
    bit busy, wq, acc, drop;
    int a;
    nm = m_mem; nr = m_rd; nrem = m_rem;
    busy = (m_rem > 0);
    wq   = bus_if.phase[PH_W] && bus_if.we;
    acc  = wq && !busy;
    drop = wq && busy;
`ifdef ZERO_REG_EN
    if (bus_if.wa == 0) begin acc = 0; drop = 0; end
`endif
    if (bus_if.phase[PH_R]) begin
      for (int k = 0; k < NRD; k++) begin
        a = int'(bus_if.ra[k*AW +: AW]);
        nr[k] = (acc && a == int'(bus_if.wa)) ? bus_if.wd : m_mem[a];
      end
    end
    if (busy) begin
      nm[DEPTH - m_rem] = '0;
      nrem = m_rem - 1;
    end else begin
      if (acc) nm[bus_if.wa] = bus_if.wd;
      if (bus_if.clr_req) nrem = DEPTH;
    end
    @(posedge clk);
    #1;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      for (int k = 0; k < NRD; k++) m_rd[k] = '0;
      m_rem = 0; m_vld = 0; m_drop = 0; m_done = 0;
    end else begin
      m_done = busy && (m_rem == 1);
      m_vld  = bus_if.phase[PH_R];
      m_drop = drop;
      m_mem  = nm; m_rd = nr; m_rem = nrem;
    end
  endtask

  task automatic set_idle();
    bus_if.phase = '0; bus_if.we = 0; bus_if.clr_req = 0;
    bus_if.wa = '0; bus_if.wd = '0; bus_if.ra = '0;
  endtask

  task automatic fill(input logic [DW-1:0] v);
    bus_if.phase = 5'b00001; bus_if.we = 1;
    for (int a = 0; a < DEPTH; a++) begin
      bus_if.wa = AW'(a); bus_if.wd = v; tick();
    end
    set_idle();
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1; tick(); tick(); rst = 0;
    n_vec++; if (bus_if.rd !== '0) begin n_miss++; $display("FAIL reset_rd: got %h want 0", bus_if.rd); end
    n_vec++; if (bus_if.rd_vld !== 1'b0 || bus_if.wr_drop !== 1'b0) begin n_miss++; $display("FAIL reset_pulses: got vld=%b drop=%b want 0 0", bus_if.rd_vld, bus_if.wr_drop); end
    n_vec++; if (bus_if.clr_busy !== 1'b0 || bus_if.clr_done !== 1'b0) begin n_miss++; $display("FAIL reset_clr: got busy=%b done=%b want 0 0", bus_if.clr_busy, bus_if.clr_done); end
    n_vec++; if (bus_if.rf_flat !== '0) begin n_miss++; $display("FAIL reset_flat: got %h want 0", bus_if.rf_flat); end
  endtask

  task automatic test_write_read();
    bus_if.phase = 5'b00001; bus_if.we = 1; bus_if.wa = 3'd5; bus_if.wd = 32'hDEADBEEF;
    tick();
    bus_if.we = 0; bus_if.phase = 5'b01000; bus_if.ra = {3'd0, 3'd5};
    n_vec++; if (rfw(5) !== 32'hDEADBEEF) begin n_miss++; $display("FAIL wr_flat5: got %h want deadbeef", rfw(5)); end
    tick();
    n_vec++; if (bus_if.rd[31:0] !== 32'hDEADBEEF) begin n_miss++; $display("FAIL rd0_addr5: got %h want deadbeef", bus_if.rd[31:0]); end
    n_vec++; if (bus_if.rd_vld !== 1'b1) begin n_miss++; $display("FAIL rd_vld_pulse: got %b want 1", bus_if.rd_vld); end
    bus_if.phase = '0;
    tick();
    n_vec++; if (bus_if.rd_vld !== 1'b0 || bus_if.rd[31:0] !== 32'hDEADBEEF) begin n_miss++; $display("FAIL rd_hold: got vld=%b rd0=%h want 0 deadbeef", bus_if.rd_vld, bus_if.rd[31:0]); end
  endtask

  task automatic test_bypass();
    bus_if.phase = 5'b01001; bus_if.we = 1; bus_if.wa = 3'd3; bus_if.wd = 32'h12345678;
    bus_if.ra = {3'd3, 3'd3};
    tick();
    set_idle();
    n_vec++; if (bus_if.rd !== {32'h12345678, 32'h12345678}) begin n_miss++; $display("FAIL bypass_rd: got %h want 1234567812345678", bus_if.rd); end
    n_vec++; if (rfw(3) !== 32'h12345678) begin n_miss++; $display("FAIL bypass_store: got %h want 12345678", rfw(3)); end
  endtask

  task automatic test_clear();
    fill(32'h11);
    bus_if.clr_req = 1; tick(); bus_if.clr_req = 0;
    for (int i = 1; i <= DEPTH; i++) begin
      n_vec++; if (bus_if.clr_busy !== 1'b1 || bus_if.clr_done !== 1'b0) begin n_miss++; $display("FAIL clr_busy_c%0d: got busy=%b done=%b want 1 0", i, bus_if.clr_busy, bus_if.clr_done); end
      tick();
    end
    n_vec++; if (bus_if.clr_busy !== 1'b0 || bus_if.clr_done !== 1'b1) begin n_miss++; $display("FAIL clr_done_c9: got busy=%b done=%b want 0 1", bus_if.clr_busy, bus_if.clr_done); end
    n_vec++; if (bus_if.rf_flat !== '0) begin n_miss++; $display("FAIL clr_flat: got %h want 0", bus_if.rf_flat); end
    tick();
    n_vec++; if (bus_if.clr_done !== 1'b0) begin n_miss++; $display("FAIL clr_done_width: got %b want 0", bus_if.clr_done); end
  endtask

  task automatic test_clear_drop();
    fill(32'h11);
    bus_if.clr_req = 1; tick(); bus_if.clr_req = 0;
    for (int i = 1; i <= DEPTH; i++) begin
      if (i == 4) begin
        bus_if.phase = 5'b00001; bus_if.we = 1; bus_if.wa = 3'd2; bus_if.wd = 32'hABCD;
      end else begin
        bus_if.phase = '0; bus_if.we = 0;
      end
      if (i == 5) begin
        n_vec++; if (bus_if.wr_drop !== 1'b1) begin n_miss++; $display("FAIL wr_drop_pulse: got %b want 1", bus_if.wr_drop); end
      end
      tick();
    end
    set_idle();
    n_vec++; if (bus_if.wr_drop !== 1'b0) begin n_miss++; $display("FAIL wr_drop_after: got %b want 0", bus_if.wr_drop); end
    bus_if.phase = 5'b01000; bus_if.ra = {3'd0, 3'd2};
    tick(); set_idle();
    n_vec++; if (bus_if.rd[31:0] !== 32'h0 || rfw(2) !== 32'h0) begin n_miss++; $display("FAIL drop_addr2: got rd0=%h word2=%h want 0 0", bus_if.rd[31:0], rfw(2)); end
  endtask

  task automatic test_clear_reset();
    fill(32'h11);
    bus_if.phase = 5'b01000; bus_if.ra = {3'd4, 3'd1};
    bus_if.clr_req = 1; tick(); set_idle();
    tick(); tick();
    rst = 1; tick(); rst = 0;
    n_vec++; if (bus_if.clr_busy !== 1'b0 || bus_if.clr_done !== 1'b0) begin n_miss++; $display("FAIL rstclr_clr: got busy=%b done=%b want 0 0", bus_if.clr_busy, bus_if.clr_done); end
    n_vec++; if (bus_if.rd !== '0 || bus_if.rd_vld !== 1'b0 || bus_if.wr_drop !== 1'b0) begin n_miss++; $display("FAIL rstclr_rd: got rd=%h vld=%b drop=%b want 0", bus_if.rd, bus_if.rd_vld, bus_if.wr_drop); end
    n_vec++; if (bus_if.rf_flat !== '0) begin n_miss++; $display("FAIL rstclr_flat: got %h want 0", bus_if.rf_flat); end
    for (int i = 0; i < DEPTH + 2; i++) begin
      tick();
      n_vec++; if (bus_if.clr_done !== 1'b0 || bus_if.clr_busy !== 1'b0) begin n_miss++; $display("FAIL rstclr_nodone_%0d: got busy=%b done=%b want 0 0", i, bus_if.clr_busy, bus_if.clr_done); end
    end
  endtask

  task automatic test_zero_reg();
    logic [DW-1:0] exp_rd, exp_byp;
`ifdef ZERO_REG_EN
    exp_rd = 32'h0; exp_byp = 32'h0;
`else
    exp_rd = 32'hFFFF; exp_byp = 32'h5A5A;
`endif
    bus_if.phase = 5'b00001; bus_if.we = 1; bus_if.wa = 3'd0; bus_if.wd = 32'hFFFF;
    tick();
    n_vec++; if (bus_if.wr_drop !== 1'b0) begin n_miss++; $display("FAIL zero_nodrop: got %b want 0", bus_if.wr_drop); end
    bus_if.we = 0; bus_if.phase = 5'b01000; bus_if.ra = {3'd0, 3'd0};
    tick();
    n_vec++; if (bus_if.rd[31:0] !== exp_rd || rfw(0) !== exp_rd) begin n_miss++; $display("FAIL zero_read: got rd0=%h word0=%h want %h", bus_if.rd[31:0], rfw(0), exp_rd); end
    bus_if.phase = 5'b01001; bus_if.we = 1; bus_if.wd = 32'h5A5A;
    tick(); set_idle();
    n_vec++; if (bus_if.rd[31:0] !== exp_byp) begin n_miss++; $display("FAIL zero_bypass: got %h want %h", bus_if.rd[31:0], exp_byp); end
  endtask

  task automatic test_random();
    rst = 1; set_idle(); tick(); rst = 0;
    for (int c = 0; c < 800; c++) begin
      bus_if.phase   = 5'($urandom_range(0, 31));
      bus_if.we      = 1'($urandom_range(0, 1));
      bus_if.wa      = 3'($urandom_range(0, DEPTH-1));
      bus_if.wd      = $urandom;
      bus_if.ra      = 6'($urandom_range(0, 63));
      bus_if.clr_req = ($urandom_range(0, 39) == 0);
      rst            = ($urandom_range(0, 149) == 0);
      tick();
      n_vec++; if (bus_if.rd !== model_rd()) begin n_miss++; $display("FAIL rnd_rd c%0d: got %h want %h", c, bus_if.rd, model_rd()); end
      n_vec++; if ({bus_if.rd_vld, bus_if.wr_drop} !== {m_vld, m_drop}) begin n_miss++; $display("FAIL rnd_pulse c%0d: got vld/drop %b%b want %b%b", c, bus_if.rd_vld, bus_if.wr_drop, m_vld, m_drop); end
      n_vec++; if ({bus_if.clr_busy, bus_if.clr_done} !== {m_rem > 0, m_done}) begin n_miss++; $display("FAIL rnd_clr c%0d: got busy/done %b%b want %b%b", c, bus_if.clr_busy, bus_if.clr_done, m_rem > 0, m_done); end
      n_vec++; if (bus_if.rf_flat !== model_flat()) begin n_miss++; $display("FAIL rnd_flat c%0d: got %h want %h", c, bus_if.rf_flat, model_flat()); end
    end
    rst = 0; set_idle();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    for (int k = 0; k < NRD; k++) m_rd[k] = '0;
    m_rem = 0; m_vld = 0; m_drop = 0; m_done = 0;
    test_reset();
    test_write_read();
    test_bypass();
    test_clear();
    test_clear_drop();
    test_clear_reset();
    test_zero_reg();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
